// File: rtl/mxu_pkg.sv
// Shared definitions for the MXU processing elements: default widths and
// signed range bounds used by the saturating accumulator.
package mxu_pkg;

  localparam int DATA_W_DEF = 32'd8;
  localparam int ACC_T_W    = 32'd32;
  localparam int BOUND_W    = 32'd64;

  // Largest signed value representable in w bits (w <= BOUND_W).
  function automatic logic [BOUND_W-1:0] max_s(input int w);
    return (64'd1 << (w - 32'd1)) - 64'd1;
  endfunction

  // Smallest signed value representable in w bits; its low w bits read 100..0.
  function automatic logic [BOUND_W-1:0] min_s(input int w);
    return ~max_s(w);
  endfunction

endpackage

// File: rtl/mxu_pipe_reg.sv
// Parametrised W-bit x DEPTH shift register with synchronous clear and
// clock enable. Used for activation/valid forwarding and the MAC tail.
module mxu_pipe_reg #(
  parameter int W     = 32'd8,
  parameter int DEPTH = 32'd2
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Advance every stage by one position on an enabled cycle, hold otherwise.
  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Stage registers; clear wins over enable so in-flight data is discarded.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/mxu_pe_ws.sv
// Weight-stationary MXU processing element: double-buffered weight,
// delayed activation forwarding, and a signed multiply-add into the partial
// sum with optional saturation and a sticky overflow flag.
module mxu_pe_ws
  import mxu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_T_W,
  parameter int LAT    = 32'd2,
  parameter int A_DLY  = 32'd2,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              ce,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_shift,
  output logic [DATA_W-1:0] w_out,
  input  logic              w_swap,
  output logic              sat_flag
);

  localparam int PROD_W = 32'd2 * DATA_W;
  localparam logic [BOUND_W-1:0] MAX_L = max_s(ACC_W);
  localparam logic [BOUND_W-1:0] MIN_L = min_s(ACC_W);
  localparam logic [ACC_W-1:0]   MAX_V = MAX_L[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   MIN_V = MIN_L[ACC_W-1:0];

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              sat_flag_q, sat_flag_d;

  logic [PROD_W-1:0] a_ext_s, w_ext_s, prod_s;
  logic [ACC_W:0]    term_s, addend_s, sum_s;
  logic              valid_s, ovf_s;
  logic [ACC_W-1:0]  res_s;
  logic [ACC_W:0]    psum_stage_s;
  logic [ACC_W:0]    psum_tail_s;

  // Weight double buffer: swap reads the pre-edge shadow, so a shift and a
  // swap in the same cycle reload without a bubble.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (ce) begin
      if (w_shift) begin
        shadow_d = w_in;
      end else begin
        shadow_d = shadow_q;
      end
      if (w_swap) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
    end else begin
      shadow_d = shadow_q;
      active_d = active_q;
    end
  end

  // Multiply-add at ACC_W+1 bits; the add is retimed into the first stage
  // and the top two sum bits disagreeing marks an out-of-range result.
  always_comb begin
    a_ext_s  = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    w_ext_s  = {{DATA_W{active_q[DATA_W-1]}}, active_q};
    prod_s   = a_ext_s * w_ext_s;
    term_s   = '0;
    addend_s = '0;
    if (a_valid_in) begin
      term_s = {{(ACC_W + 1 - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end else begin
      term_s = '0;
    end
    if (psum_valid_in) begin
      addend_s = {psum_in[ACC_W-1], psum_in};
    end else begin
      addend_s = '0;
    end
    sum_s   = term_s + addend_s;
    valid_s = a_valid_in | psum_valid_in;
    ovf_s   = valid_s & (sum_s[ACC_W] ^ sum_s[ACC_W-1]);
    res_s   = sum_s[ACC_W-1:0];
    if (ovf_s && SAT) begin
      if (sum_s[ACC_W]) begin
        res_s = MIN_V;
      end else begin
        res_s = MAX_V;
      end
    end else begin
      res_s = sum_s[ACC_W-1:0];
    end
    psum_stage_s = {valid_s, res_s};
  end

  // Sticky overflow flag, raised on the enabled cycle the overflow is sampled.
  always_comb begin
    sat_flag_d = sat_flag_q;
    if (ce && ovf_s) begin
      sat_flag_d = 1'b1;
    end else begin
      sat_flag_d = sat_flag_q;
    end
  end

  // Weight and flag registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (sclr) begin
      shadow_q   <= '0;
      active_q   <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  mxu_pipe_reg #(.W(DATA_W), .DEPTH(A_DLY)) u_a_dly (
    .clk (clk), .sclr(sclr), .ce(ce), .d(a_in), .q(a_out)
  );

  mxu_pipe_reg #(.W(32'd1), .DEPTH(A_DLY)) u_av_dly (
    .clk (clk), .sclr(sclr), .ce(ce), .d(a_valid_in), .q(a_valid_out)
  );

  mxu_pipe_reg #(.W(ACC_W + 32'd1), .DEPTH(LAT)) u_psum_dly (
    .clk (clk), .sclr(sclr), .ce(ce), .d(psum_stage_s), .q(psum_tail_s)
  );

  assign psum_valid_out = psum_tail_s[ACC_W];
  assign psum_out       = psum_tail_s[ACC_W-1:0];
  assign w_out          = shadow_q;
  assign sat_flag       = sat_flag_q;

endmodule

// File: tb/tb_mxu_pe_ws.sv
// Self-checking bench for mxu_pe_ws: two instances (saturating and wrapping)
// share one stimulus; a vector table covers the steady-state datapath and
// hand-written sequences cover saturation, stall and mid-stream reset.
module tb_mxu_pe_ws;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          sclr, ce;
  logic [DW-1:0] a_in, w_in;
  logic          a_valid_in, psum_valid_in, w_shift, w_swap;
  logic [AW-1:0] psum_in;

  logic [DW-1:0] a_out_1, a_out_0, w_out_1, w_out_0;
  logic          a_valid_out_1, a_valid_out_0;
  logic [AW-1:0] psum_out_1, psum_out_0;
  logic          psum_valid_out_1, psum_valid_out_0, sat_flag_1, sat_flag_0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mxu_pe_ws #(.DATA_W(DW), .ACC_W(AW), .LAT(2), .A_DLY(2), .SAT(1'b1)) dut_sat (
    .clk(clk), .sclr(sclr), .ce(ce),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out_1), .a_valid_out(a_valid_out_1),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in),
    .psum_out(psum_out_1), .psum_valid_out(psum_valid_out_1),
    .w_in(w_in), .w_shift(w_shift), .w_out(w_out_1), .w_swap(w_swap), .sat_flag(sat_flag_1)
  );

  mxu_pe_ws #(.DATA_W(DW), .ACC_W(AW), .LAT(2), .A_DLY(2), .SAT(1'b0)) dut_wrap (
    .clk(clk), .sclr(sclr), .ce(ce),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out_0), .a_valid_out(a_valid_out_0),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in),
    .psum_out(psum_out_0), .psum_valid_out(psum_valid_out_0),
    .w_in(w_in), .w_shift(w_shift), .w_out(w_out_0), .w_swap(w_swap), .sat_flag(sat_flag_0)
  );

  typedef struct {
    int a;  bit av; int p; bit pv;
    int w;  bit sh; bit sw;
    int ep; bit ev; int ewo;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  function automatic vec_t mk(int a, bit av, int p, bit pv, int w, bit sh, bit sw,
                              int ep, bit ev, int ewo);
    vec_t v;
    v.a = a; v.av = av; v.p = p; v.pv = pv; v.w = w; v.sh = sh; v.sw = sw;
    v.ep = ep; v.ev = ev; v.ewo = ewo;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input bit av, input int p, input bit pv,
                       input int w, input bit sh, input bit sw);
    a_in          = a[DW-1:0];
    a_valid_in    = av;
    psum_in       = p[AW-1:0];
    psum_valid_in = pv;
    w_in          = w[DW-1:0];
    w_shift       = sh;
    w_swap        = sw;
  endtask

  task automatic idle();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Both instances must agree on psum when no overflow is involved.
  task automatic chk_psum(input string name, input int e1, input int e0, input bit ev);
    chk({name, " psum_sat"},   $signed(psum_out_1), e1);
    chk({name, " psum_wrap"},  $signed(psum_out_0), e0);
    chk({name, " pvalid_sat"}, psum_valid_out_1, ev);
    chk({name, " pvalid_wrap"}, psum_valid_out_0, ev);
  endtask

  task automatic chk_flags(input string name, input bit e);
    chk({name, " flag_sat"},  sat_flag_1, e);
    chk({name, " flag_wrap"}, sat_flag_0, e);
  endtask

  task automatic chk_all_zero(input string name);
    chk_psum(name, 0, 0, 1'b0);
    chk({name, " a_out"},   $signed(a_out_1), 0);
    chk({name, " a_valid"}, a_valid_out_1, 0);
    chk({name, " w_out"},   $signed(w_out_1), 0);
    chk({name, " w_out_wrap"}, $signed(w_out_0), 0);
    chk_flags(name, 1'b0);
  endtask

  initial begin
    // a, av, p, pv, w, sh, sw | expected psum, valid, w_out after this row
    tbl[0]  = mk(   0, 0,      0, 0,    3, 1, 0,      0, 0,    3);
    tbl[1]  = mk(   0, 0,      0, 0,    0, 0, 1,      0, 0,    3);
    tbl[2]  = mk(   5, 1,     10, 1,    0, 0, 0,     25, 1,    3);
    tbl[3]  = mk(   0, 0,      0, 0,   -2, 1, 1,      0, 0,   -2);
    tbl[4]  = mk(   4, 1,      0, 1,    0, 0, 0,     12, 1,   -2);
    tbl[5]  = mk(   4, 1,      0, 0,    0, 0, 1,     12, 1,   -2);
    tbl[6]  = mk(   4, 1,      0, 0,    0, 0, 0,     -8, 1,   -2);
    tbl[7]  = mk(   7, 0,    100, 1,    0, 0, 0,    100, 1,   -2);
    tbl[8]  = mk(   7, 0,    100, 0,    0, 0, 0,      0, 0,   -2);
    tbl[9]  = mk(   0, 0,      0, 0, -128, 1, 0,      0, 0, -128);
    tbl[10] = mk(   0, 0,      0, 0,    0, 0, 1,      0, 0, -128);
    tbl[11] = mk(-128, 1,      0, 1,    0, 0, 0,  16384, 1, -128);
    tbl[12] = mk(-128, 1,  16383, 1,    0, 0, 0,  32767, 1, -128);
    tbl[13] = mk(-128, 1,     -1, 1,    0, 0, 0,  16383, 1, -128);
    tbl[14] = mk( 127, 1,      0, 1,    0, 0, 0, -16256, 1, -128);
    tbl[15] = mk( 127, 1, -16512, 1,    0, 0, 0, -32768, 1, -128);

    // Reset with ce low: everything reads zero.
    sclr = 1'b1; ce = 1'b0; idle();
    step(); step();
    chk_all_zero("reset");
    sclr = 1'b0; ce = 1'b1;

    // Vector table: psum/a_out lag their row by two cycles, w_out by one.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(tbl[i].a, tbl[i].av, tbl[i].p, tbl[i].pv,
                        tbl[i].w, tbl[i].sh, tbl[i].sw);
      else idle();
      step();
      if (i < NV) chk($sformatf("row%0d w_out", i), $signed(w_out_1), tbl[i].ewo);
      if (i >= 1) begin
        chk_psum($sformatf("row%0d", i - 1), tbl[i-1].ep, tbl[i-1].ep, tbl[i-1].ev);
        chk($sformatf("row%0d a_out", i - 1), $signed(a_out_1), tbl[i-1].a);
        chk($sformatf("row%0d a_valid", i - 1), a_valid_out_1, tbl[i-1].av);
        chk_flags($sformatf("row%0d", i - 1), 1'b0);
      end
    end

    // Saturation: 127*127 + 32767 = 48896 -> clamp 32767 / wrap -16640.
    drive(0, 1'b0, 0, 1'b0, 127, 1'b1, 1'b0); step();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);   step();
    drive(127, 1'b1, 32767, 1'b1, 0, 1'b0, 1'b0); step();
    idle(); step();
    chk_psum("sat_pos", 32767, -16640, 1'b1);
    chk_flags("sat_pos", 1'b1);
    drive(1, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0); step();
    idle(); step();
    chk_psum("sat_clean", 127, 127, 1'b1);
    chk_flags("sat_sticky", 1'b1);
    // -128*127 - 32768 = -49024 -> clamp -32768 / wrap 16512.
    drive(-128, 1'b1, -32768, 1'b1, 0, 1'b0, 1'b0); step();
    idle(); step();
    chk_psum("sat_neg", -32768, 16512, 1'b1);

    // Stall for three cycles with garbage on every input.
    drive(1, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0); step();
    drive(2, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0); step();
    chk_psum("stall_pre", 127, 127, 1'b1);
    ce = 1'b0;
    drive(99, 1'b1, 1234, 1'b1, 55, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_psum($sformatf("stall%0d", k), 127, 127, 1'b1);
      chk($sformatf("stall%0d a_out", k), $signed(a_out_1), 1);
      chk($sformatf("stall%0d w_out", k), $signed(w_out_1), 127);
    end
    ce = 1'b1;
    drive(3, 1'b1, -1, 1'b1, 0, 1'b0, 1'b0); step();
    chk_psum("stall_v1", 259, 259, 1'b1);
    chk("stall_v1 a_out", $signed(a_out_1), 2);
    idle(); step();
    chk_psum("stall_v2", 380, 380, 1'b1);
    idle(); step();
    chk_psum("stall_drain", 0, 0, 1'b0);

    // Reset while stalled with results in flight.
    drive(2, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0); step();
    drive(1, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0); step();
    chk_psum("rst_pre", 257, 257, 1'b1);
    ce = 1'b0; sclr = 1'b1; step();
    sclr = 1'b0;
    chk_all_zero("rst_mid");
    step();
    chk_psum("rst_hold", 0, 0, 1'b0);
    ce = 1'b1; idle(); step();
    chk_psum("rst_idle1", 0, 0, 1'b0);
    step();
    chk_psum("rst_idle2", 0, 0, 1'b0);
    drive(9, 1'b1, 55, 1'b1, 0, 1'b0, 1'b0); step();
    idle(); step();
    chk_psum("rst_zero_w", 55, 55, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
